// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a DEPTH-entry
// output queue and valid/ready handshakes on both sides.
// Decodes the I/S/B/U/J immediates, sign-extended to XLEN from instr[31].
// Optional feature macro: IMMGEN_CSR_EN -- when defined, CSRR*I instructions
// (opcode 1110011, funct3[2]=1) yield the zero-extended zimm with fmt=5.
// When undefined, that opcode decodes as "no immediate".
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [31:0]            instr,
    output logic                   imm_valid,
    input  logic                   imm_ready,
    output logic [XLEN-1:0]        imm,
    output logic [2:0]             imm_fmt,
    output logic                   imm_illegal,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
`ifdef IMMGEN_CSR_EN
    localparam logic [2:0] FMT_CSR  = 3'd5;
`endif
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    // Immediate decode: start from a full sign fill of instr[31], then overlay
    // the format-specific low bits so no zero-width replication is needed.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.imm     = {XLEN{w[31]}};
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                d.imm[11:0] = w[31:20];
                d.fmt       = FMT_I;
            end
            7'b0100011: begin
                d.imm[11:0] = {w[31:25], w[11:7]};
                d.fmt       = FMT_S;
            end
            7'b1100011: begin
                d.imm[12:0] = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                d.fmt       = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                d.imm[31:0] = {w[31:12], 12'b0};
                d.fmt       = FMT_U;
            end
            7'b1101111: begin
                d.imm[20:0] = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                d.fmt       = FMT_J;
            end
`ifdef IMMGEN_CSR_EN
            7'b1110011: begin
                if (w[14]) begin
                    d.imm      = {XLEN{1'b0}};
                    d.imm[4:0] = w[19:15];
                    d.fmt      = FMT_CSR;
                end else begin
                    d.imm     = {XLEN{1'b0}};
                    d.fmt     = FMT_NONE;
                    d.illegal = 1'b1;
                end
            end
`endif
            default: begin
                d.imm     = {XLEN{1'b0}};
                d.fmt     = FMT_NONE;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [XLEN-1:0] imm_mem_r [DEPTH];
    logic [2:0]      fmt_mem_r [DEPTH];
    logic            ill_mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            ready_r;

    logic            push_s;
    logic            pop_s;
    logic            not_empty_s;
    logic [LW-1:0]   level_nxt_s;
    dec_t            dec_s;

    // Handshake qualification, next occupancy and write-side decode.
    always_comb begin
        not_empty_s = (level_r != LW'(0));
        push_s      = instr_valid & ready_r;
        pop_s       = not_empty_s & imm_ready;
        dec_s       = decode(instr);
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Queue storage: decoded entries are written at the tail on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem_r[i] <= {XLEN{1'b0}};
                fmt_mem_r[i] <= FMT_NONE;
                ill_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            imm_mem_r[wr_ptr_r] <= dec_s.imm;
            fmt_mem_r[wr_ptr_r] <= dec_s.fmt;
            ill_mem_r[wr_ptr_r] <= dec_s.illegal;
        end
    end

    // Pointers, occupancy and the registered accept flag; a pop in a full
    // cycle only frees the slot for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            level_r  <= LW'(0);
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s < LW'(DEPTH));
        end
    end

    // Head mux: storage straight to the outputs, neutral values when empty.
    always_comb begin
        if (not_empty_s) begin
            imm         = imm_mem_r[rd_ptr_r];
            imm_fmt     = fmt_mem_r[rd_ptr_r];
            imm_illegal = ill_mem_r[rd_ptr_r];
        end else begin
            imm         = {XLEN{1'b0}};
            imm_fmt     = FMT_NONE;
            imm_illegal = 1'b0;
        end
    end

    assign imm_valid   = not_empty_s;
    assign instr_ready = ready_r;
    assign level       = level_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// A 32-bit and a 64-bit instance share the same stimulus.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        imm_ready;
    logic [31:0] instr;

    logic        instr_ready;
    logic        imm_valid;
    logic [31:0] imm;
    logic [2:0]  imm_fmt;
    logic        imm_illegal;
    logic [1:0]  level;

    logic        instr_ready64;
    logic        imm_valid64;
    logic [63:0] imm64;
    logic [2:0]  imm_fmt64;
    logic        imm_illegal64;
    logic [1:0]  level64;

    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .imm_valid(imm_valid), .imm_ready(imm_ready), .imm(imm),
        .imm_fmt(imm_fmt), .imm_illegal(imm_illegal), .level(level)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready64), .instr(instr),
        .imm_valid(imm_valid64), .imm_ready(imm_ready), .imm(imm64),
        .imm_fmt(imm_fmt64), .imm_illegal(imm_illegal64), .level(level64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi_imm(input int k);
        return {12'(k), 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    task automatic do_push(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_pop();
        imm_ready = 1'b1;
        @(posedge clk);
        #1;
        imm_ready = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] e_imm,
                               input logic [2:0] e_fmt, input logic e_ill);
        @(negedge clk);
        check({tag, "_valid"}, 64'(imm_valid), 64'(1'b1));
        check({tag, "_imm"},   64'(imm),       64'(e_imm));
        check({tag, "_fmt"},   64'(imm_fmt),   64'(e_fmt));
        check({tag, "_ill"},   64'(imm_illegal), 64'(e_ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   popped;
        int   idx;
        logic acc;
        logic pp;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        imm_ready   = 1'b0;
        instr       = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid",   64'(imm_valid),   64'(1'b0));
        check("rst_ready",   64'(instr_ready), 64'(1'b0));
        check("rst_level",   64'(level),       64'(2'd0));
        check("rst_imm",     64'(imm),         64'(32'h0));
        check("rst_fmt",     64'(imm_fmt),     64'(3'd7));
        check("rst_ill",     64'(imm_illegal), 64'(1'b0));
        check("rst_valid64", 64'(imm_valid64), 64'(1'b0));
        check("rst_level64", 64'(level64),     64'(2'd0));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst",   64'(instr_ready),   64'(1'b1));
        check("rdy_after_rst64", 64'(instr_ready64), 64'(1'b1));

        // I-type negative, one cycle after acceptance
        do_push(32'hFFF00093);
        expect_head("itype", 32'hFFFFFFFF, 3'd0, 1'b0);
        check("itype_level", 64'(level), 64'(2'd1));
        check("itype_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
        do_pop();
        @(negedge clk);
        check("empty_valid", 64'(imm_valid), 64'(1'b0));
        check("empty_imm",   64'(imm),       64'(32'h0));
        check("empty_fmt",   64'(imm_fmt),   64'(3'd7));

        // S then B back-to-back with consumer ready
        imm_ready   = 1'b1;
        instr       = 32'hFE112E23;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = 32'hFE000CE3;
        expect_head("stype", 32'hFFFFFFFC, 3'd1, 1'b0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        expect_head("btype", 32'hFFFFFFF8, 3'd2, 1'b0);
        check("btype_level", 64'(level), 64'(2'd1));
        @(posedge clk);
        #1;
        imm_ready = 1'b0;
        @(negedge clk);
        check("sb_drained", 64'(imm_valid), 64'(1'b0));

        // U-type at both widths
        do_push(32'h123450B7);
        expect_head("utype", 32'h12345000, 3'd3, 1'b0);
        do_pop();
        do_push(32'h800000B7);
        expect_head("utype_neg", 32'h80000000, 3'd3, 1'b0);
        check("utype_imm64", imm64, 64'hFFFFFFFF_80000000);
        check("utype_fmt64", 64'(imm_fmt64), 64'(3'd3));
        check("utype_ill64", 64'(imm_illegal64), 64'(1'b0));
        do_pop();

        // J-type and a positive load offset
        do_push(32'hFF9FF06F);
        expect_head("jtype", 32'hFFFFFFF8, 3'd4, 1'b0);
        do_pop();
        do_push(32'h00812083);
        expect_head("load", 32'h00000008, 3'd0, 1'b0);
        do_pop();

        // Opcodes without an immediate, and the CSR zimm form
        do_push(32'h00000033);
        expect_head("rtype", 32'h0, 3'd7, 1'b1);
        do_pop();
        do_push(32'h300FD073);
`ifdef IMMGEN_CSR_EN
        expect_head("csr", 32'h0000001F, 3'd5, 1'b0);
`else
        expect_head("csr", 32'h0, 3'd7, 1'b1);
`endif
        do_pop();

        // Back-pressure, full-with-pop, and pointer wrap over 7 entries
        @(negedge clk);
        check("bp_start_level", 64'(level), 64'(2'd0));
        @(posedge clk);
        #1;
        popped      = 0;
        idx         = 0;
        instr       = addi_imm(1);
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && popped < 7; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                check("bp_full_level", 64'(level), 64'(2'd2));
                check("bp_full_ready", 64'(instr_ready), 64'(1'b0));
                check("bp_head_c2", 64'(imm), 64'(32'd1));
            end
            if (cyc == 3) begin
                check("bp_hold_level", 64'(level), 64'(2'd2));
                check("bp_hold_head", 64'(imm), 64'(32'd1));
                check("bp_held_idx", 64'(idx), 64'(2));
                imm_ready = 1'b1;
            end
            if (cyc == 4) begin
                check("bp_no_push_on_full_pop", 64'(level), 64'(2'd1));
            end
            acc = instr_valid & instr_ready;
            pp  = imm_valid & imm_ready;
            if (pp) begin
                check("bp_order", 64'(imm), 64'(popped + 1));
                popped++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 7) begin
                    instr = addi_imm(idx + 1);
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        imm_ready = 1'b0;
        check("bp_popped", 64'(popped), 64'(7));
        @(negedge clk);
        check("bp_end_level", 64'(level), 64'(2'd0));

        // Asynchronous reset while full
        @(posedge clk);
        #1;
        do_push(32'h00100093);
        do_push(32'h00200093);
        @(negedge clk);
        check("rmid_level_pre", 64'(level), 64'(2'd2));
        #2 rst_n = 1'b0;
        #1;
        check("rmid_valid", 64'(imm_valid),   64'(1'b0));
        check("rmid_level", 64'(level),       64'(2'd0));
        check("rmid_ready", 64'(instr_ready), 64'(1'b0));
        check("rmid_fmt",   64'(imm_fmt),     64'(3'd7));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rrel_ready", 64'(instr_ready), 64'(1'b1));
        check("rrel_valid", 64'(imm_valid),   64'(1'b0));
        @(negedge clk);
        check("rrel_no_stale", 64'(imm_valid), 64'(1'b0));
        do_push(32'h00300093);
        expect_head("rrel_new", 32'h00000003, 3'd0, 1'b0);
        do_pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
